// File: rtl/udp_pkg.sv
// Shared constants, types and CRC helper for the UDP receive path.
// Holds the Ethernet/IPv4/UDP header offsets, frame size limits and state encoding.
// Used by rmii_recv_byte and udp_recv; no ports.
package udp_pkg;

  typedef logic [10:0] cnt_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRE,
    ST_DATA,
    ST_CHECK,
    ST_DROP
  } state_t;

  localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
  localparam logic [7:0]  IP_VER_IHL     = 8'h45;
  localparam logic [7:0]  IP_PROTO_UDP   = 8'h11;
  localparam logic [31:0] CRC_POLY_REFL  = 32'hEDB88320;
  localparam logic [31:0] CRC_RESIDUE    = 32'hDEBB20E3;
  localparam logic [31:0] CRC_INIT       = 32'hFFFFFFFF;
  localparam cnt_t        MIN_FRAME      = 11'd64;
  localparam cnt_t        MAX_FRAME      = 11'd1518;

  // Byte offsets counted from the first byte after the SFD.
  localparam cnt_t OFS_ETYPE   = 11'd12;
  localparam cnt_t OFS_VER     = 11'd14;
  localparam cnt_t OFS_PROTO   = 11'd23;
  localparam cnt_t OFS_DIP     = 11'd30;
  localparam cnt_t OFS_DPORT   = 11'd36;
  localparam cnt_t OFS_ULEN    = 11'd38;
  localparam cnt_t OFS_PAYLOAD = 11'd42;

  // Reflected CRC32, one byte per call, no final inversion.
  function automatic logic [31:0] crc32_byte(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'h0, b};
    for (int i = 0; i < 8; i++) begin
      r = r[0] ? ((r >> 1) ^ CRC_POLY_REFL) : (r >> 1);
    end
    return r;
  endfunction

endpackage

// File: rtl/udp_recv_if.sv
// Payload write bus and frame status from the UDP receiver.
// Ports: addr/data/we carry provisional payload bytes; rdy/err are one-cycle frame verdicts.
// master = receiver side (drives), slave = consumer side (samples).
interface udp_recv_if #(
  parameter int Nsz = 5
);
  logic [Nsz-1:0] addr;
  logic [7:0]     data;
  logic           we;
  logic           rdy;
  logic           err;

  modport master (output addr, data, we, rdy, err);
  modport slave  (input  addr, data, we, rdy, err);
endinterface

// File: rtl/udp_recv_rmii.sv
// RMII receive front end: input register, preamble/SFD detection, dibit-to-byte assembly.
// Ports: clk, rst, rm_rx_data/rm_crs_dv in; rx_byte, byte_stb, sof, eof, align_err out.
// Strobes are decoded from the registered sample, so they coincide with the completing dibit.
module rmii_recv_byte
  import udp_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] rm_rx_data,
  input  logic       rm_crs_dv,
  output logic [7:0] rx_byte,
  output logic       byte_stb,
  output logic       sof,
  output logic       eof,
  output logic       align_err
);

  logic [1:0] rx_q;
  logic       dv_q;
  state_t     state;
  logic [1:0] phase;
  logic [5:0] sh;     // first three dibits of the byte, newest at the top

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_q  <= 2'b00;
      dv_q  <= 1'b0;
      state <= ST_IDLE;
      phase <= 2'd0;
      sh    <= 6'd0;
    end else begin
      rx_q <= rm_rx_data;
      dv_q <= rm_crs_dv;
      case (state)
        ST_IDLE: begin
          if (dv_q && rx_q == 2'b01) state <= ST_PRE;
        end
        ST_PRE: begin
          if (!dv_q)               state <= ST_IDLE;
          else if (rx_q == 2'b11) begin
            state <= ST_DATA;
            phase <= 2'd0;
          end
          else if (rx_q != 2'b01)  state <= ST_DROP;
        end
        ST_DATA: begin
          if (!dv_q) begin
            state <= ST_IDLE;
          end else begin
            phase <= phase + 2'd1;
            sh    <= {rx_q, sh[5:2]};
          end
        end
        ST_DROP: begin
          if (!dv_q) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // LSB dibit arrives first, so the current dibit is the top of the byte.
  assign rx_byte   = {rx_q, sh};
  assign byte_stb  = (state == ST_DATA) && dv_q && (phase == 2'd3);
  assign sof       = (state == ST_PRE) && dv_q && (rx_q == 2'b11);
  assign eof       = (state == ST_DATA) && !dv_q && (phase == 2'd0);
  assign align_err = (state == ST_DATA) && !dv_q && (phase != 2'd0);

endmodule

// File: rtl/udp_recv.sv
// UDP receiver: filters Ethernet/IPv4/UDP frames for this node, writes payload, checks FCS.
// Ports: clk, rst, rm_rx_data, rm_crs_dv in; wr (addr/data/we/rdy/err) master out.
// we follows a completed payload byte by one cycle; rdy/err one cycle after carrier drops.
module udp_recv
  import udp_pkg::*;
#(
  parameter logic [47:0] mac_addr = 48'h00_12_34_56_78_90,
  parameter logic [31:0] dst_ip   = {8'd192, 8'd168, 8'd0, 8'd2},
  parameter logic [15:0] dst_port = 16'd10241,
  parameter int          p_sz     = 18,
  parameter int          Nsz      = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [1:0]   rm_rx_data,
  input  logic         rm_crs_dv,
  udp_recv_if.master   wr
);

  localparam logic [15:0] ULEN    = 16'(8 + p_sz);
  localparam cnt_t        PAY_END = OFS_PAYLOAD + cnt_t'(p_sz);

  logic [7:0]  rx_byte;
  logic        byte_stb, sof, eof, align_err;

  state_t      state;
  cnt_t        cnt;
  logic [31:0] crc;
  logic        mac_uc, mac_bc;     // destination MAC still matches unicast / broadcast
  logic        mac_uc_n, mac_bc_n;
  logic [7:0]  mac_b;
  logic        hdr_ok;
  logic        fcs_good;

  rmii_recv_byte u_rx (
    .clk        (clk),
    .rst        (rst),
    .rm_rx_data (rm_rx_data),
    .rm_crs_dv  (rm_crs_dv),
    .rx_byte    (rx_byte),
    .byte_stb   (byte_stb),
    .sof        (sof),
    .eof        (eof),
    .align_err  (align_err)
  );

  // Header byte compare against the byte at the current offset.
  always_comb begin
    hdr_ok   = 1'b1;
    mac_uc_n = mac_uc;
    mac_bc_n = mac_bc;
    mac_b    = 8'h00;
    case (cnt)
      11'd0:   mac_b = mac_addr[47:40];
      11'd1:   mac_b = mac_addr[39:32];
      11'd2:   mac_b = mac_addr[31:24];
      11'd3:   mac_b = mac_addr[23:16];
      11'd4:   mac_b = mac_addr[15:8];
      11'd5:   mac_b = mac_addr[7:0];
      default: mac_b = 8'h00;
    endcase
    if (cnt < 11'd6) begin
      mac_uc_n = mac_uc & (rx_byte == mac_b);
      mac_bc_n = mac_bc & (rx_byte == 8'hFF);
      hdr_ok   = mac_uc_n | mac_bc_n;
    end
    case (cnt)
      OFS_ETYPE:          hdr_ok = (rx_byte == ETHERTYPE_IPV4[15:8]);
      OFS_ETYPE + 11'd1:  hdr_ok = (rx_byte == ETHERTYPE_IPV4[7:0]);
      OFS_VER:            hdr_ok = (rx_byte == IP_VER_IHL);
      OFS_PROTO:          hdr_ok = (rx_byte == IP_PROTO_UDP);
      OFS_DIP:            hdr_ok = (rx_byte == dst_ip[31:24]);
      OFS_DIP + 11'd1:    hdr_ok = (rx_byte == dst_ip[23:16]);
      OFS_DIP + 11'd2:    hdr_ok = (rx_byte == dst_ip[15:8]);
      OFS_DIP + 11'd3:    hdr_ok = (rx_byte == dst_ip[7:0]);
      OFS_DPORT:          hdr_ok = (rx_byte == dst_port[15:8]);
      OFS_DPORT + 11'd1:  hdr_ok = (rx_byte == dst_port[7:0]);
      OFS_ULEN:           hdr_ok = (rx_byte == ULEN[15:8]);
      OFS_ULEN + 11'd1:   hdr_ok = (rx_byte == ULEN[7:0]);
      default: ;
    endcase
  end

  // The CRC already includes the FCS bytes when carrier drops.
  assign fcs_good = (crc == CRC_RESIDUE) && (cnt >= MIN_FRAME);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      crc     <= CRC_INIT;
      mac_uc  <= 1'b0;
      mac_bc  <= 1'b0;
      wr.we   <= 1'b0;
      wr.rdy  <= 1'b0;
      wr.err  <= 1'b0;
      wr.addr <= '0;
      wr.data <= '0;
    end else begin
      wr.we  <= 1'b0;
      wr.rdy <= 1'b0;
      wr.err <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (sof) begin
            state  <= ST_DATA;
            cnt    <= '0;
            crc    <= CRC_INIT;
            mac_uc <= 1'b1;
            mac_bc <= 1'b1;
          end
        end
        ST_DATA: begin
          if (align_err) begin
            wr.err <= 1'b1;
            state  <= ST_IDLE;
          end else if (eof) begin
            // Verdict is registered here so it is visible during the CHECK cycle.
            wr.rdy <= fcs_good;
            wr.err <= !fcs_good;
            state  <= ST_CHECK;
          end else if (byte_stb) begin
            crc    <= crc32_byte(crc, rx_byte);
            cnt    <= cnt + 11'd1;
            mac_uc <= mac_uc_n;
            mac_bc <= mac_bc_n;
            if (!hdr_ok) begin
              state <= ST_DROP;
            end else if (cnt == MAX_FRAME - 11'd1) begin
              wr.err <= 1'b1;
              state  <= ST_DROP;
            end else if (cnt >= OFS_PAYLOAD && cnt < PAY_END) begin
              wr.we   <= 1'b1;
              wr.addr <= Nsz'(cnt - OFS_PAYLOAD);
              wr.data <= rx_byte;
            end
          end
        end
        ST_CHECK: state <= ST_IDLE;
        ST_DROP: begin
          // The front end reports the carrier drop as either eof or align_err.
          if (eof || align_err) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
